keccak_byte_packer: RTL

KECCAK_BYTE_PACKER -- requirements
Module: keccak_byte_packer

---
 rtl/keccak_pkg.sv | 18 +
 rtl/keccak_byte_packer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/keccak_pkg.sv
// Shared definitions for the keccak input-side blocks.
//   WORD_W  : width of a word handed to the keccak core
//   BYTE_W  : width of one message byte
//   state_e : 3-bit state encoding of the byte packer
package keccak_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_ACCUM     = 3'd0,
    ST_WORD      = 3'd1,
    ST_FULL_LAST = 3'd2,
    ST_TAIL      = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

endpackage : keccak_pkg

// File: rtl/keccak_byte_packer.sv
// Packs a byte stream into 32-bit words for the keccak core input.
// One message per reset; the message must hold at least one byte.
//
// Ports
//   clk           : clock, all state changes on the rising edge
//   reset         : synchronous, active-high
//   s_data/s_valid/s_last/s_ready : byte stream in (handshake)
//   word_out      : word to core "in"
//   word_valid    : to core in_ready; a word transfers whenever it is 1
//   word_last     : to core is_last
//   word_byte_num : to core byte_num (valid bytes of the last word)
//   buffer_full   : from core; suppresses word_valid while high
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_ACCUM     | collecting bytes into word_q, s_ready high
// ST_WORD      | full non-final word pending
// ST_FULL_LAST | final byte completed a word; full word pending
// ST_TAIL      | final (possibly empty) word pending with word_last=1
// ST_DONE      | message finished, idle until reset
module keccak_byte_packer
  import keccak_pkg::*;
#(
  parameter int BYTE_ORDER_MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              word_last,
  output logic [1:0]        word_byte_num,
  input  logic              buffer_full
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        bnum_q, bnum_d;
  logic [1:0]        lane;

  function automatic logic [WORD_W-1:0] insert_lane(input logic [WORD_W-1:0] w,
                                                    input logic [1:0]        idx,
                                                    input logic [BYTE_W-1:0] b);
    logic [WORD_W-1:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  // Byte cnt lands in lane 3-cnt so the first byte ends up in [31:24].
  assign lane = (BYTE_ORDER_MSB_FIRST != 0) ? (2'd3 - cnt_q) : cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACCUM;
      cnt_q   <= 2'd0;
      word_q  <= '0;
      bnum_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      bnum_q  <= bnum_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACCUM: begin
        if (s_valid) begin
          if (s_last) state_d = (cnt_q == 2'd3) ? ST_FULL_LAST : ST_TAIL;
          else if (cnt_q == 2'd3) state_d = ST_WORD;
        end
      end
      ST_WORD:      if (word_valid) state_d = ST_ACCUM;
      ST_FULL_LAST: if (word_valid) state_d = ST_TAIL;
      ST_TAIL:      if (word_valid) state_d = ST_DONE;
      ST_DONE:      state_d = ST_DONE;
      default:      state_d = ST_ACCUM;
    endcase
  end

  // Datapath next values. word_q is cleared after each sent word so that
  // unused lanes of a partial final word are already zero.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    bnum_d = bnum_q;
    unique case (state_q)
      ST_ACCUM: begin
        if (s_valid) begin
          word_d = insert_lane(word_q, lane, s_data);
          if (s_last) begin
            bnum_d = (cnt_q == 2'd3) ? 2'd0 : cnt_q + 2'd1;
            cnt_d  = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;  // wraps 3 -> 0 on a full word
          end
        end
      end
      ST_WORD: if (word_valid) word_d = '0;
      ST_FULL_LAST: begin
        if (word_valid) begin
          word_d = '0;
          bnum_d = 2'd0;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    s_ready       = (state_q == ST_ACCUM);
    word_valid    = ((state_q == ST_WORD) || (state_q == ST_FULL_LAST) ||
                     (state_q == ST_TAIL)) && !buffer_full;
    word_last     = (state_q == ST_TAIL);
    word_byte_num = (state_q == ST_TAIL) ? bnum_q : 2'd0;
    word_out      = word_q;
  end

endmodule : keccak_byte_packer
